// File: rtl/serial_paralelo_sync.sv
// ---------------------------------------------------------------------------
// serial_paralelo_sync
//
// Serial-to-parallel receiver with comma-based word alignment. Shifts the
// serial line into a WIDTH-bit register (MSB first), hunts for COMMA or ~COMMA
// to find the word boundary, confirms the alignment with SYNC_COUNT
// consecutive aligned commas, and then emits every aligned word with a
// one-cycle valid strobe. Lock is dropped after LOSS_COUNT misaligned commas.
//
// Build option:
//   SP_COMMA_DROP_EN  when defined, comma words seen while locked are swallowed:
//                     no valid strobe, salidas keeps the previous data and
//                     es_comma stays low. When undefined, commas are emitted
//                     like data with es_comma=1.
//
// Ports:
//   clk           in   1      bit clock, posedge
//   rst           in   1      asynchronous reset, active-high
//   enb           in   1      bit enable; when low, all state holds
//   entrada       in   1      serial bit, MSB of each word first
//   salidas       out  WIDTH  aligned parallel word, registered
//   valid         out  1      one-cycle strobe, salidas holds a new word
//   es_comma      out  1      emitted word is COMMA/~COMMA (qualifies valid)
//   sincronizado  out  1      high while locked
//   estado        out  2      0=LOSS 1=ACQUIRE 2=LOCKED (3 behaves as LOSS)
//
// state      | meaning
// -----------+--------------------------------------------------------------
// ST_LOSS    | no alignment; any comma in the shift register sets the boundary
// ST_ACQUIRE | boundary tentative; counting consecutive aligned commas
// ST_LOCKED  | aligned; words emitted, misaligned commas counted
// ---------------------------------------------------------------------------
module serial_paralelo_sync #(
   parameter int unsigned      WIDTH      = 10,
   parameter logic [WIDTH-1:0] COMMA      = 10'b0011111010,
   parameter int unsigned      SYNC_COUNT = 4,
   parameter int unsigned      LOSS_COUNT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enb,
   input  logic             entrada,
   output logic [WIDTH-1:0] salidas,
   output logic             valid,
   output logic             es_comma,
   output logic             sincronizado,
   output logic [1:0]       estado
);

   localparam int unsigned       PW         = $clog2(WIDTH);
   localparam logic [PW-1:0]     PHASE_LAST = PW'(WIDTH - 1);
   localparam logic [3:0]        SYNC_LAST  = 4'(SYNC_COUNT - 1);
   localparam logic [3:0]        LOSS_LAST  = 4'(LOSS_COUNT - 1);

   typedef enum logic [1:0] {
      ST_LOSS    = 2'd0,
      ST_ACQUIRE = 2'd1,
      ST_LOCKED  = 2'd2
   } state_t;

   state_t            state_q;
   logic [WIDTH-1:0]  sr_q;
   logic [WIDTH-1:0]  salidas_q;
   logic              valid_q;
   logic              es_comma_q;
   logic [PW-1:0]     phase_q;
   logic [3:0]        comma_cnt_q;
   logic [3:0]        err_cnt_q;

   logic              match;
   logic              boundary;

   assign match    = (sr_q == COMMA) | (sr_q == ~COMMA);
   // phase_q is only meaningful once a boundary has been established
   assign boundary = (phase_q == PHASE_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_LOSS;
         sr_q        <= '0;
         salidas_q   <= '0;
         valid_q     <= 1'b0;
         es_comma_q  <= 1'b0;
         phase_q     <= '0;
         comma_cnt_q <= '0;
         err_cnt_q   <= '0;
      end else begin
         // strobes last exactly one cycle, also across enb=0 cycles
         valid_q    <= 1'b0;
         es_comma_q <= 1'b0;
         if (enb) begin
            sr_q <= {sr_q[WIDTH-2:0], entrada};
            case (state_q)
               ST_ACQUIRE: begin
                  if (boundary) begin
                     phase_q <= '0;
                     if (match) begin
                        if (comma_cnt_q >= SYNC_LAST) begin
                           state_q     <= ST_LOCKED;
                           comma_cnt_q <= '0;
                           err_cnt_q   <= '0;
                        end else begin
                           comma_cnt_q <= comma_cnt_q + 4'd1;
                        end
                     end else begin
                        state_q     <= ST_LOSS;
                        comma_cnt_q <= '0;
                     end
                  end else begin
                     phase_q <= phase_q + 1'b1;
                  end
               end

               ST_LOCKED: begin
                  if (boundary) begin
                     phase_q <= '0;
`ifdef SP_COMMA_DROP_EN
                     if (!match) begin
                        salidas_q <= sr_q;
                        valid_q   <= 1'b1;
                     end
`else
                     salidas_q  <= sr_q;
                     valid_q    <= 1'b1;
                     es_comma_q <= match;
`endif
                     if (match) begin
                        err_cnt_q <= '0;
                     end
                  end else begin
                     phase_q <= phase_q + 1'b1;
                     if (match) begin
                        // the comma shifts out on this same edge, so it can
                        // never be picked up again by the LOSS hunt
                        if (err_cnt_q >= LOSS_LAST) begin
                           state_q   <= ST_LOSS;
                           err_cnt_q <= '0;
                        end else begin
                           err_cnt_q <= err_cnt_q + 4'd1;
                        end
                     end
                  end
               end

               default: begin
                  // ST_LOSS and the unused encoding
                  state_q <= ST_LOSS;
                  if (match) begin
                     phase_q <= '0;
                     if (SYNC_COUNT <= 1) begin
                        state_q     <= ST_LOCKED;
                        comma_cnt_q <= '0;
                        err_cnt_q   <= '0;
                     end else begin
                        state_q     <= ST_ACQUIRE;
                        comma_cnt_q <= 4'd1;
                     end
                  end
               end
            endcase
         end
      end
   end

   assign salidas      = salidas_q;
   assign valid        = valid_q;
   assign es_comma     = es_comma_q;
   assign sincronizado = (state_q == ST_LOCKED);
   assign estado       = state_q;

endmodule

// File: tb/tb_serial_paralelo_sync.sv
// ---------------------------------------------------------------------------
// tb_serial_paralelo_sync
//
// Directed bench for serial_paralelo_sync with default parameters
// (WIDTH=10, K28.5 comma, SYNC_COUNT=4, LOSS_COUNT=4). Expected values are
// hand-derived constants; comma-emission expectations follow SP_COMMA_DROP_EN.
// ---------------------------------------------------------------------------
module tb_serial_paralelo_sync;

   localparam logic [9:0] C_COMMA = 10'b0011111010;
   localparam logic [9:0] C_DATA  = 10'b1010010101;
   localparam logic [9:0] C_W5    = 10'b1111100000;
   localparam logic [9:0] C_ZERO1 = 10'b0000000001;
   localparam logic [9:0] C_SHF1  = 10'b1001111101;
   localparam logic [9:0] C_SHF0  = 10'b0001111101;

   logic       clk;
   logic       rst;
   logic       enb;
   logic       entrada;
   logic [9:0] salidas;
   logic       valid;
   logic       es_comma;
   logic       sincronizado;
   logic [1:0] estado;

   int n_checks = 0;
   int n_fail   = 0;

   serial_paralelo_sync dut (
      .clk          (clk),
      .rst          (rst),
      .enb          (enb),
      .entrada      (entrada),
      .salidas      (salidas),
      .valid        (valid),
      .es_comma     (es_comma),
      .sincronizado (sincronizado),
      .estado       (estado)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0b, expected %0b", tag, obs, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      entrada = b;
      enb     = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // sends w[hi] down to w[lo]
   task automatic send_part(input logic [9:0] w, input int hi, input int lo);
      for (int i = hi; i >= lo; i--) send_bit(w[i]);
   endtask

   task automatic send_word(input logic [9:0] w);
      send_part(w, 9, 0);
   endtask

   task automatic idle_cycle();
      enb = 1'b0;
      @(posedge clk);
      #1;
   endtask

   // expectations for a comma word emitted while locked
   task automatic check_comma_emit(input string tag, input logic [9:0] prev);
`ifdef SP_COMMA_DROP_EN
      check_val({tag, "_valid"},    valid,    0);
      check_val({tag, "_es_comma"}, es_comma, 0);
      check_val({tag, "_salidas"},  salidas,  prev);
`else
      check_val({tag, "_valid"},    valid,    1);
      check_val({tag, "_es_comma"}, es_comma, 1);
      check_val({tag, "_salidas"},  salidas,  C_COMMA);
`endif
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst     = 1'b1;
      enb     = 1'b0;
      entrada = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_val("rst_salidas",  salidas,      0);
      check_val("rst_valid",    valid,        0);
      check_val("rst_es_comma", es_comma,     0);
      check_val("rst_sinc",     sincronizado, 0);
      check_val("rst_estado",   estado,       0);
      rst = 1'b0;

      // acquisition: junk 101 then four commas
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
      send_word(C_COMMA);
      check_val("t1_c1_estado", estado, 0);
      send_word(C_COMMA);
      check_val("t1_c2_estado", estado, 1);
      send_word(C_COMMA);
      send_word(C_COMMA);
      check_val("t1_c4_estado", estado, 1);
      check_val("t1_c4_sinc",   sincronizado, 0);

      // locked data word, strobe one edge after its last bit
      send_word(C_DATA);
      check_val("t2_estado",      estado,       2);
      check_val("t2_sinc",        sincronizado, 1);
      check_val("t2_valid_early", valid,        0);
      send_part(C_COMMA, 9, 9);
      check_val("t2_valid",       valid,    1);
      check_val("t2_salidas",     salidas,  C_DATA);
      check_val("t2_es_comma",    es_comma, 0);
      send_part(C_COMMA, 8, 8);
      check_val("t2_valid_off",   valid,    0);
      check_val("t2_salidas_hold", salidas, C_DATA);
      send_part(C_COMMA, 7, 0);

      // comma emission, then a word stalled by 7 enb=0 cycles
      send_part(C_W5, 9, 9);
      check_comma_emit("t2c", C_DATA);
      send_part(C_W5, 8, 5);
      for (int i = 0; i < 7; i++) begin
         idle_cycle();
         if (i == 3) check_val("t5_valid_stall", valid, 0);
      end
      send_part(C_W5, 4, 0);
      check_val("t5_valid_early", valid, 0);
      send_part(C_COMMA, 9, 9);
      check_val("t5_valid",    valid,    1);
      check_val("t5_salidas",  salidas,  C_W5);
      check_val("t5_es_comma", es_comma, 0);
      send_part(C_COMMA, 8, 0);

      // one extra bit, then misaligned commas drop lock on the fourth
      send_bit(1'b1);
      check_comma_emit("t4c", C_W5);
      send_word(C_COMMA);
      check_val("t4_s1_valid",   valid,   1);
      check_val("t4_s1_salidas", salidas, C_SHF1);
      check_val("t4_s1_estado",  estado,  2);
      send_word(C_COMMA);
      send_word(C_COMMA);
      check_val("t4_s3_estado",  estado,  2);
      send_word(C_COMMA);
      check_val("t4_s4_estado",  estado,  2);
      check_val("t4_s4_valid",   valid,   1);
      check_val("t4_s4_salidas", salidas, C_SHF0);
      send_part(C_COMMA, 9, 9);
      check_val("t4_loss_estado",  estado,       0);
      check_val("t4_loss_sinc",    sincronizado, 0);
      check_val("t4_loss_valid",   valid,        0);
      check_val("t4_loss_salidas", salidas,      C_SHF0);
      send_part(C_COMMA, 8, 0);
      check_val("t4_r1_estado", estado, 0);
      send_word(C_COMMA);
      check_val("t4_r2_estado", estado, 1);
      send_word(C_COMMA);
      send_word(C_COMMA);
      check_val("t4_r4_estado", estado, 1);
      send_part(C_DATA, 9, 9);
      check_val("t4_relock_estado", estado,       2);
      check_val("t4_relock_sinc",   sincronizado, 1);

      // async reset mid-word while locked
      send_part(C_DATA, 8, 0);
      send_bit(1'b0);
      check_val("t6_valid_pre",   valid,   1);
      check_val("t6_salidas_pre", salidas, C_DATA);
      send_bit(1'b1);
      send_bit(1'b1);
      #2;
      rst = 1'b1;
      #1;
      check_val("t6_salidas",  salidas,      0);
      check_val("t6_valid",    valid,        0);
      check_val("t6_es_comma", es_comma,     0);
      check_val("t6_sinc",     sincronizado, 0);
      check_val("t6_estado",   estado,       0);
      enb = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;

      // non-comma at a boundary in ACQUIRE falls back to LOSS
      send_word(C_COMMA);
      check_val("t3_c1_estado", estado, 0);
      send_word(C_COMMA);
      check_val("t3_c2_estado", estado, 1);
      send_word(C_ZERO1);
      check_val("t3_z_estado",  estado, 1);
      send_bit(1'b0);
      check_val("t3_loss_estado", estado,       0);
      check_val("t3_loss_sinc",   sincronizado, 0);
      check_val("t3_loss_valid",  valid,        0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
